// File: rtl/i2s_transceiver.sv
// Stereo I2S master: derives BCLK/LRCLK from clk, shifts DAC samples out MSB first
// and assembles ADC samples into parallel left/right words once per frame.
//   state | meaning
//   IDLE  | bclk/lrclk/sdata held low, divider and bit counter frozen
//   RUN   | divider running, frames in progress; leaves only at a frame boundary
module i2s_transceiver #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int BCLK_DIV   = 8,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_enable,
   input  logic [DATA_WIDTH-1:0] tx_left,
   input  logic [DATA_WIDTH-1:0] tx_right,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_underrun,
   output logic [DATA_WIDTH-1:0] rx_left,
   output logic [DATA_WIDTH-1:0] rx_right,
   output logic                  rx_valid,
   output logic                  o_bclk,
   output logic                  o_lrclk,
   output logic                  o_sdata,
   input  logic                  i_sdata
);
   localparam int FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [BW-1:0]        B_LAST   = BW'(FRAME_BITS - 1);
   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(BCLK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [BW-1:0]         b_q, b_d;
   logic                  bclk_q, lrclk_q, sdata_q, rx_valid_q;
   logic [DATA_WIDTH-1:0] tx_l_q, tx_r_q, tx_l_d, tx_r_d;
   logic [DATA_WIDTH-1:0] rx_l_sh_q, rx_r_sh_q, rx_l_sh_d, rx_r_sh_d;
   logic [DATA_WIDTH-1:0] rx_left_q, rx_right_q;
   logic                  tick, rise, fall, at_end, ready;
   logic                  lrclk_d, sdata_d, in_left, in_right, rx_last;
   logic [31:0]           bn, bq;

   always_comb begin
      tick    = (state_q == RUN) && (div_q == DIV_LAST);
      rise    = tick && !bclk_q;
      fall    = tick && bclk_q;
      at_end  = (b_q == B_LAST);
      ready   = fall && at_end && i_enable;
      b_d     = at_end ? '0 : b_q + BW'(1);
      tx_l_d  = tx_l_q;
      tx_r_d  = tx_r_q;
      if (ready) begin
         tx_l_d = tx_valid ? tx_left  : '0;
         tx_r_d = tx_valid ? tx_right : '0;
      end
      // Data and word select are driven for the bit the falling edge advances into.
      bn      = 32'(b_d);
      bq      = 32'(b_q);
      lrclk_d = (bn >= 32'(SLOT_WIDTH - 1)) && (bn <= 32'(FRAME_BITS - 2));
      sdata_d = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (bn == 32'(DATA_WIDTH - 1 - i))              sdata_d = tx_l_d[i];
         if (bn == 32'(SLOT_WIDTH + DATA_WIDTH - 1 - i)) sdata_d = tx_r_d[i];
      end
      in_left   = bq < 32'(DATA_WIDTH);
      in_right  = (bq >= 32'(SLOT_WIDTH)) && (bq < 32'(SLOT_WIDTH + DATA_WIDTH));
      rx_last   = rise && (bq == 32'(SLOT_WIDTH + DATA_WIDTH - 1));
      rx_l_sh_d = (rx_l_sh_q << 1) | DATA_WIDTH'(i_sdata);
      rx_r_sh_d = (rx_r_sh_q << 1) | DATA_WIDTH'(i_sdata);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         div_q      <= '0;
         b_q        <= B_LAST;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_l_q     <= '0;
         tx_r_q     <= '0;
         rx_l_sh_q  <= '0;
         rx_r_sh_q  <= '0;
         rx_left_q  <= '0;
         rx_right_q <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_enable) state_q <= RUN;
            end
            RUN: begin
               if (tick) begin
                  div_q  <= '0;
                  bclk_q <= ~bclk_q;
               end else begin
                  div_q  <= div_q + DIV_WIDTH'(1);
               end
               if (fall) begin
                  if (at_end && !i_enable) begin
                     state_q <= IDLE;
                     lrclk_q <= 1'b0;
                     sdata_q <= 1'b0;
                  end else begin
                     b_q     <= b_d;
                     lrclk_q <= lrclk_d;
                     sdata_q <= sdata_d;
                     tx_l_q  <= tx_l_d;
                     tx_r_q  <= tx_r_d;
                  end
               end
               if (rise) begin
                  if (in_left)  rx_l_sh_q <= rx_l_sh_d;
                  if (in_right) rx_r_sh_q <= rx_r_sh_d;
                  if (rx_last) begin
                     rx_left_q  <= rx_l_sh_q;
                     rx_right_q <= rx_r_sh_d;
                     rx_valid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_ready    = ready;
   assign tx_underrun = ready && !tx_valid;
   assign rx_left     = rx_left_q;
   assign rx_right    = rx_right_q;
   assign rx_valid    = rx_valid_q;
   assign o_bclk      = bclk_q;
   assign o_lrclk     = lrclk_q;
   assign o_sdata     = sdata_q;
endmodule

// File: tb/tb_i2s_transceiver.sv
// Loopback bench for i2s_transceiver: frame-level model of the serial stream and
// a queue of expected received words checked by an independent monitor.
module tb_i2s_transceiver;
   localparam int DW         = 24;
   localparam int SW         = 32;
   localparam int DIV        = 8;
   localparam int FRAME_BITS = 2 * SW;
   localparam int FRAME_CLK  = FRAME_BITS * 2 * DIV;

   logic          clk = 1'b0;
   logic          rst_n, i_enable, tx_valid;
   logic [DW-1:0] tx_left, tx_right, rx_left, rx_right;
   logic          tx_ready, tx_underrun, rx_valid;
   logic          o_bclk, o_lrclk, o_sdata;
   logic          i_sdata;

   assign i_sdata = o_sdata;
   always #5 clk = ~clk;

   i2s_transceiver #(
      .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV), .DIV_WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
      .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_underrun(tx_underrun),
      .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
      .o_bclk(o_bclk), .o_lrclk(o_lrclk), .o_sdata(o_sdata), .i_sdata(i_sdata)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_timeouts = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // model state
   bit            model_idle = 1'b1, frame_active = 1'b0, pending = 1'b0;
   bit            wait_rise = 1'b0, prev_bclk = 1'b0, en_prev = 1'b0;
   int            tb_b = -1, rxcnt = 0, enter_cyc = 0, last_ready = -1, seen_to = 0;
   logic [DW-1:0] cur_l = '0, cur_r = '0, pend_l = '0, pend_r = '0;
   logic [2*DW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_bit(input int b);
      if (b < DW) return cur_l[DW-1-b];
      if (b >= SW && b < SW + DW) return cur_r[DW-1-(b-SW)];
      return 1'b0;
   endfunction

   function automatic bit exp_lr(input int b);
      return (b >= SW - 1) && (b <= 2 * SW - 2);
   endfunction

   // monitor / scoreboard
   initial begin
      logic [2*DW-1:0] front;
      bit fall;
      forever begin
         @(negedge clk);
         if (n_timeouts != seen_to) begin
            chk("wait_timeout", 64'(n_timeouts), 64'(seen_to));
            seen_to = n_timeouts;
         end
         if (!rst_n) begin
            chk("reset_outputs", 64'({o_bclk, o_lrclk, o_sdata, tx_ready, tx_underrun,
                                      rx_valid, rx_left, rx_right}), 64'(0));
            model_idle = 1'b1; frame_active = 1'b0; pending = 1'b0; wait_rise = 1'b0;
            last_ready = -1; rxcnt = 0; prev_bclk = 1'b0; exp_q.delete();
            en_prev = i_enable;
         end else begin
            fall = prev_bclk && !o_bclk;
            if (!model_idle) begin
               if (wait_rise && o_bclk) begin
                  chk("first_rise_delay", 64'(cyc - enter_cyc), 64'(DIV));
                  wait_rise = 1'b0;
               end
               if (fall) begin
                  if (!frame_active) chk("first_fall_b0", 64'(pending), 64'(1));
                  else if (tb_b == FRAME_BITS - 1) begin
                     chk("ready_at_boundary", 64'(pending), 64'(en_prev));
                     chk("rx_once_per_frame", 64'(rxcnt), 64'(1));
                  end else chk("ready_mid_frame", 64'(pending), 64'(0));
                  if (pending) begin
                     tb_b = 0; frame_active = 1'b1; pending = 1'b0; rxcnt = 0;
                     cur_l = pend_l; cur_r = pend_r;
                  end else if (frame_active && tb_b == FRAME_BITS - 1) begin
                     model_idle = 1'b1; frame_active = 1'b0; last_ready = -1;
                  end else if (frame_active) tb_b++;
                  if (frame_active) begin
                     chk("lrclk", 64'(o_lrclk), 64'(exp_lr(tb_b)));
                     chk("sdata", 64'(o_sdata), 64'(exp_bit(tb_b)));
                  end
               end
               if (tx_ready) begin
                  chk("underrun", 64'(tx_underrun), 64'(!tx_valid));
                  if (last_ready >= 0) chk("ready_period", 64'(cyc - last_ready), 64'(FRAME_CLK));
                  last_ready = cyc;
                  pending = 1'b1;
                  pend_l = tx_valid ? tx_left : '0;
                  pend_r = tx_valid ? tx_right : '0;
                  exp_q.push_back({pend_l, pend_r});
               end else chk("underrun_without_ready", 64'(tx_underrun), 64'(0));
               if (rx_valid) begin
                  chk("rx_valid_position", 64'(frame_active ? tb_b : -1), 64'(SW + DW - 1));
                  rxcnt++;
                  if (exp_q.size() == 0) chk("rx_unexpected", 64'(1), 64'(0));
                  else begin
                     front = exp_q.pop_front();
                     chk("rx_data", 64'({rx_left, rx_right}), 64'(front));
                  end
               end
            end
            if (model_idle) begin
               chk("idle_outputs", 64'({o_bclk, o_lrclk, o_sdata, tx_ready, rx_valid}), 64'(0));
               if (i_enable) begin
                  model_idle = 1'b0; wait_rise = 1'b1; enter_cyc = cyc + 1; last_ready = -1;
               end
            end
            prev_bclk = o_bclk;
            en_prev   = i_enable;
         end
      end
   end

   // sample source: new random words after each accepted frame, with periodic underruns
   initial begin
      int k;
      k = 0;
      tx_left  = 24'hA5A5A5;
      tx_right = 24'h5A5A5A;
      tx_valid = 1'b1;
      forever begin
         @(posedge tx_ready);
         @(posedge clk);
         #2;
         k++;
         tx_left  = DW'($urandom);
         tx_right = DW'($urandom);
         tx_valid = (k % 4 == 2) ? 1'b0 : ($urandom_range(0, 7) != 0);
      end
   end

   task automatic wait_b(input int target);
      for (int k = 0; k < 2 * FRAME_CLK; k++) begin
         @(posedge clk);
         if (frame_active && tb_b == target) return;
      end
      n_timeouts++;
   endtask

   initial begin
      rst_n = 1'b0;
      i_enable = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2 i_enable = 1'b1;
      repeat (6 * FRAME_CLK + 40) @(posedge clk);
      wait_b(10);
      #2 i_enable = 1'b0;
      repeat (3 * FRAME_CLK) @(posedge clk);
      #2 i_enable = 1'b1;
      repeat (FRAME_CLK) @(posedge clk);
      wait_b(40);
      #3 rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4 * FRAME_CLK) @(posedge clk);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
